mac_rx_parser: RTL

Receive-side MAC stage that sits directly downstream of the RGMII PHY block and consumes its byte stream (phy_rxd / phy_rvalid / phy_rready / phy_rerr). It strips preamble and SFD, filters on destination MAC, checks the CRC-32 FCS, removes the FCS, and emits the frame as a byte stream with last and error flags. It also keeps good/bad frame counters.

---
 rtl/mac_rx_parser.sv | 132 +++++++++++++
 1 files changed

// File: rtl/mac_rx_parser.sv
// Receive MAC stage: strips preamble/SFD, filters destination address, checks the FCS,
// strips it, and streams the frame out with last/error flags plus good/bad frame counters.
module mac_rx_parser #(
    parameter logic [47:0] LOCAL_MAC   = 48'h00_0A_35_00_01_02,
    parameter bit          PROMISCUOUS = 1'b0,
    parameter int unsigned MIN_FRAME   = 64,
    parameter int unsigned MAX_FRAME   = 1522
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic [7:0]  phy_rxd_in,
    input  logic        phy_rvalid_in,
    output logic        phy_rready_out,
    input  logic        phy_rerr_in,
    output logic [7:0]  mac_rdata_out,
    output logic        mac_rvalid_out,
    output logic        mac_rlast_out,
    output logic        mac_rerr_out,
    output logic [15:0] stat_good_cnt,
    output logic [15:0] stat_bad_cnt
);

    localparam logic [31:0] CrcResidue = 32'hDEBB20E3;
    localparam logic [10:0] MinLen     = 11'(MIN_FRAME);
    localparam logic [10:0] MaxLen     = 11'(MAX_FRAME);

    typedef enum logic [1:0] {StIdle, StPreamble, StData, StDrop} state_e;

    state_e      state_q;
    logic [31:0] crc_q;
    logic [10:0] cnt_q;
    logic        err_q;
    logic [47:0] addr_q;
    logic [7:0]  dly_q [5];

    logic        accept;
    logic [31:0] crc_next;
    logic [47:0] dst_full;
    logic        addr_ok;
    logic        frame_bad;

    // Reflected CRC-32, LSB first.
    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c ^ {24'h0, d};
        for (int i = 0; i < 8; i++) begin
            r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        end
        return r;
    endfunction

    assign phy_rready_out = ~sys_rst;
    assign accept         = phy_rvalid_in & phy_rready_out;
    assign crc_next       = crc_byte(crc_q, phy_rxd_in);
    assign dst_full       = {addr_q[39:0], phy_rxd_in};
    assign addr_ok        = PROMISCUOUS || (dst_full == LOCAL_MAC) || (dst_full == 48'hFFFF_FFFF_FFFF);
    assign frame_bad      = (crc_q != CrcResidue) || err_q || (cnt_q < MinLen) || (cnt_q > MaxLen);

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q        <= StIdle;
            crc_q          <= 32'hFFFF_FFFF;
            cnt_q          <= '0;
            err_q          <= 1'b0;
            addr_q         <= '0;
            for (int i = 0; i < 5; i++) dly_q[i] <= '0;
            mac_rdata_out  <= '0;
            mac_rvalid_out <= 1'b0;
            mac_rlast_out  <= 1'b0;
            mac_rerr_out   <= 1'b0;
            stat_good_cnt  <= '0;
            stat_bad_cnt   <= '0;
        end else begin
            mac_rvalid_out <= 1'b0;
            mac_rlast_out  <= 1'b0;
            mac_rerr_out   <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (accept) state_q <= (phy_rxd_in == 8'h55) ? StPreamble : StDrop;
                end
                StPreamble: begin
                    if (!phy_rvalid_in) begin
                        state_q <= StIdle;
                    end else if (accept) begin
                        if (phy_rxd_in == 8'hD5) begin
                            state_q <= StData;
                            crc_q   <= 32'hFFFF_FFFF;
                            cnt_q   <= '0;
                            err_q   <= 1'b0;
                        end else if (phy_rxd_in != 8'h55) begin
                            state_q <= StDrop;
                        end
                    end
                end
                StData: begin
                    if (!phy_rvalid_in) begin
                        state_q <= StIdle;
                        // Fewer than 6 bytes means the address was never decided.
                        if (cnt_q >= 11'd6) begin
                            mac_rvalid_out <= 1'b1;
                            mac_rlast_out  <= 1'b1;
                            mac_rerr_out   <= frame_bad;
                            mac_rdata_out  <= dly_q[0];
                            if (frame_bad) stat_bad_cnt  <= stat_bad_cnt + 16'd1;
                            else           stat_good_cnt <= stat_good_cnt + 16'd1;
                        end else begin
                            stat_bad_cnt <= stat_bad_cnt + 16'd1;
                        end
                    end else if (accept) begin
                        crc_q <= crc_next;
                        if (cnt_q != 11'h7FF) cnt_q <= cnt_q + 11'd1;
                        if (phy_rerr_in) err_q <= 1'b1;
                        for (int i = 0; i < 4; i++) dly_q[i] <= dly_q[i+1];
                        dly_q[4] <= phy_rxd_in;
                        if (cnt_q < 11'd6) addr_q <= dst_full;
                        if ((cnt_q == 11'd5) && !addr_ok) begin
                            state_q <= StDrop;
                        end else if (cnt_q >= 11'd5) begin
                            mac_rvalid_out <= 1'b1;
                            mac_rdata_out  <= dly_q[0];
                        end
                    end
                end
                StDrop: begin
                    if (!phy_rvalid_in) state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule
